prim_word_serializer: RTL and testbench
=======================================

# prim_word_serializer

Parallel-to-serial stage that sits directly downstream of the packer FIFO when the packer runs in unpack mode with OutW = 8. It accepts one W-bit word per valid/ready handshake and shifts it out LSB-first on a single-bit line with UART-style framing: start bit, W data bits, optional parity, and 1 or 2 stop bits. Each bit lasts a programmable number of clocks. The block drives the device's serial TX pin logic.

## Interface
Parameters:
- W, 8, data word width (1..16)
- DivW, 16, width of the bit-period divider
- StopBits, 1, number of stop bits (1 or 2)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clr_i  in  1  synchronous clear; aborts any frame, returns to IDLE
- en_i  in  1  enables acceptance of new words; does not abort a frame in flight
- div_i  in  DivW  bit period minus 1, in clocks (0 means 1 clock per bit)
- parity_en_i  in  1  insert parity bit after the data bits
- parity_odd_i  in  1  1 = odd parity, 0 = even parity
- valid_i  in  1  upstream word valid
- data_i  in  W  upstream word
- ready_o  out  1  word accepted when valid_i && ready_o
- tx_o  out  1  serial line; idle high
- busy_o  out  1  frame in progress (state != IDLE)
- done_o  out  1  one-cycle pulse in the final clock of the last stop bit

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- clr_q is a flop of clr_i and resets to 1, so the block is held in clear for the first cycle after reset.
- ready_o = (state == IDLE) && en_i && !clr_q.
- On accept:
  - Latch data_i into the shift register.
  - Snapshot div_i, parity_en_i and parity_odd_i. Later changes to these inputs do not affect the frame in flight.
  - Go to START.
- Bit-period counter loads the latched div on every bit boundary and decrements to 0. A bit ends on the cycle where the counter is 0 (the "tick").
- Transitions on tick:
  - START → DATA, with bit index = 0.
  - DATA: shift right and increment the index. After index W-1, go to PARITY if parity is enabled, otherwise to STOP.
  - PARITY → STOP.
  - STOP: after StopBits ticks, go to IDLE.
- tx_o level per state:
  - IDLE and STOP: 1.
  - START: 0.
  - DATA: shift register bit 0.
  - PARITY: XOR of the latched word, XORed with parity_odd.
- tx_o is registered (no glitches). tx_o changes only on bit boundaries.
- done_o is asserted in the last cycle of STOP.
- clr_q forces IDLE, tx_o = 1, zeroes the counter, index and shift register, and deasserts done_o. A partial frame is truncated. No done_o pulse is produced for it.
- en_i dropping mid-frame: the frame completes and no new word is accepted.
- valid_i while busy: ignored and held upstream. Upstream must keep data_i stable until accepted.

## Timing
- Reset values: tx_o = 1, ready_o = 0, busy_o = 0, done_o = 0. ready_o can rise in the second cycle after reset deasserts.
- Accept at rising edge k:
  - tx_o = 0 and busy_o = 1 from cycle k+1.
  - Each bit lasts exactly div+1 cycles.
- Frame length = (1 + W + parity_en + StopBits) × (div+1) cycles, measured from cycle k+1.
- done_o is high in the final frame cycle. State is IDLE and ready_o is high (if en_i) in the following cycle. This gives one idle cycle between back-to-back frames, which is required.
- Simultaneous clr_i and valid_i: clr wins the next cycle, because ready_o is low while clr_q is set. No accept occurs.
- div_i = 0: one bit per clock. No gaps within a frame.
- div_i = all ones: counter wraps correctly with no overflow. Period = 2^DivW clocks.

## Structure
- prim_serializer_pkg holds:
  - the state enum ser_state_e (IDLE, START, DATA, PARITY, STOP), 3-bit, explicit encodings;
  - the localparam widths derived from W (index width = $clog2(W+1)).
- Sub-module prim_serializer_tick: a DivW down-counter with load input, enable input and tick output. It is reused later by the receive-side deserializer.
- Assertions:
  - tx_o is stable between ticks;
  - busy_o is 0 whenever ready_o is 1;
  - done_o is followed by IDLE;
  - tx_o is 1 in IDLE.

## Test plan
- Reset release, en_i=1, W=8, div_i=0, word 8'hA5, no parity, 1 stop: tx_o sequence is 0,1,0,1,0,0,1,0,1,1 (one bit per clock); done_o pulses on the 10th cycle; ready_o rises on the 11th.
- div_i=3, even parity, word 8'h07: every bit is held 4 cycles; parity bit = 1; frame length 44 cycles; changing div_i mid-frame has no effect.
- Odd parity, StopBits=2, word 8'h00: parity bit = 1; two stop bits (8 cycles at div 3); exactly one done_o pulse.
- Back-to-back: valid_i held high with 3 words: each accepted exactly one cycle after the previous done_o; no lost or duplicated words; frames are separated by 1 idle-high cycle.
- clr_i asserted during DATA bit 3: tx_o = 1 and busy_o = 0 the cycle after clr_q; no done_o; the next word sends a full, correct frame.
- Asynchronous reset asserted mid-frame: all outputs return to reset values immediately; ready_o stays low for one cycle after reset deasserts.

Source files
------------

// File: rtl/prim_serializer_pkg.sv
// prim_serializer_pkg: shared state encoding and width helpers for the serializer family
package prim_serializer_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } ser_state_e;

    localparam int unsigned MaxW = 16;

    // Bit-index width for a W-bit word; wide enough to also count stop bits.
    function automatic int unsigned idx_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/prim_serializer_tick.sv
// prim_serializer_tick: loadable bit-period down-counter, tick when it reaches zero
module prim_serializer_tick #(
    parameter int unsigned DivW = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clr_i,
    input  logic            load_i,
    input  logic [DivW-1:0] load_val_i,
    input  logic            en_i,
    output logic            tick_o
);

    logic [DivW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == '0);

    // Clear beats load beats decrement; wrap at zero is avoided by reloading on tick.
    always_comb cnt_d = clr_i ? '0 : load_i ? load_val_i : en_i ? cnt_q - DivW'(1) : cnt_q;

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/prim_word_serializer.sv
// prim_word_serializer: UART-style LSB-first serializer with start, parity and stop bits
module prim_word_serializer
    import prim_serializer_pkg::*;
#(
    parameter int unsigned W        = 8,
    parameter int unsigned DivW     = 16,
    parameter int unsigned StopBits = 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clr_i,
    input  logic            en_i,
    input  logic [DivW-1:0] div_i,
    input  logic            parity_en_i,
    input  logic            parity_odd_i,
    input  logic            valid_i,
    input  logic [W-1:0]    data_i,
    output logic            ready_o,
    output logic            tx_o,
    output logic            busy_o,
    output logic            done_o
);

    localparam int unsigned IdxW = idx_width(W);

    ser_state_e      state_q, state_d;
    logic [W-1:0]    shift_q, shift_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [DivW-1:0] div_q;
    logic            pen_q, par_q, clr_q, tx_q, tx_d;
    logic            tick, accept, busy;

    assign busy    = (state_q != IDLE);
    assign ready_o = !busy && en_i && !clr_q;
    assign accept  = valid_i && ready_o;
    assign busy_o  = busy;
    assign tx_o    = tx_q;

    prim_serializer_tick #(.DivW(DivW)) u_tick (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (clr_q),
        .load_i     (accept || (busy && tick)),
        .load_val_i (accept ? div_i : div_q),
        .en_i       (busy),
        .tick_o     (tick)
    );

    // Frame sequencing; tx level is derived from the next state so the line is registered.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        done_o  = 1'b0;
        if (clr_q) begin
            state_d = IDLE;
            shift_d = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    state_d = START;
                    shift_d = data_i;
                    idx_d   = '0;
                end
                START: if (tick) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
                DATA: if (tick) begin
                    shift_d = shift_q >> 1;
                    idx_d   = (idx_q == IdxW'(W - 1)) ? '0 : idx_q + IdxW'(1);
                    if (idx_q == IdxW'(W - 1)) state_d = pen_q ? PARITY : STOP;
                end
                PARITY: if (tick) begin
                    state_d = STOP;
                    idx_d   = '0;
                end
                STOP: if (tick) begin
                    idx_d = (idx_q == IdxW'(StopBits - 1)) ? '0 : idx_q + IdxW'(1);
                    if (idx_q == IdxW'(StopBits - 1)) begin
                        state_d = IDLE;
                        done_o  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        tx_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] :
               (state_d == PARITY) ? par_q : 1'b1;
    end

    // State, datapath and per-frame configuration snapshot; clear is held for one cycle out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            div_q   <= '0;
            pen_q   <= 1'b0;
            par_q   <= 1'b0;
            clr_q   <= 1'b1;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            clr_q   <= clr_i;
            tx_q    <= tx_d;
            if (accept) begin
                div_q <= div_i;
                pen_q <= parity_en_i;
                par_q <= ^data_i ^ parity_odd_i;
            end
        end
    end

    a_tx_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !$stable(tx_o) |-> $past(accept || clr_q || (busy && tick)));
    a_ready_not_busy: assert property (@(posedge clk_i) disable iff (!rst_ni) ready_o |-> !busy_o);
    a_done_then_idle: assert property (@(posedge clk_i) disable iff (!rst_ni) done_o |=> state_q == IDLE);
    a_idle_tx_high: assert property (@(posedge clk_i) disable iff (!rst_ni) state_q == IDLE |-> tx_o);

endmodule

// File: tb/tb_prim_word_serializer.sv
// tb_prim_word_serializer: random and directed frames against a bit-list reference model
module tb_prim_word_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  clr, en, pen, podd, valid, ready, tx, busy, done;
    logic [7:0]  data [2];
    logic [15:0] div0;
    logic [3:0]  div1;
    int          n_tests = 0;
    int          n_fail = 0;
    bit          drop_en = 1'b0;
    bit          exp_q[$];

    always #5 clk = ~clk;

    prim_word_serializer #(.W(8), .DivW(16), .StopBits(1)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr[0]), .en_i(en[0]), .div_i(div0),
        .parity_en_i(pen[0]), .parity_odd_i(podd[0]), .valid_i(valid[0]), .data_i(data[0]),
        .ready_o(ready[0]), .tx_o(tx[0]), .busy_o(busy[0]), .done_o(done[0])
    );

    prim_word_serializer #(.W(8), .DivW(4), .StopBits(2)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr[1]), .en_i(en[1]), .div_i(div1),
        .parity_en_i(pen[1]), .parity_odd_i(podd[1]), .valid_i(valid[1]), .data_i(data[1]),
        .ready_o(ready[1]), .tx_o(tx[1]), .busy_o(busy[1]), .done_o(done[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected line level for every clock of a frame, built from the framing rules.
    task automatic build(input logic [7:0] w, input int d, input bit p_en, input bit p_odd, input int stops);
        bit seq[$];
        int ones;
        ones = $countones(w);
        exp_q.delete();
        seq.push_back(1'b0);
        for (int b = 0; b < 8; b++) seq.push_back(w[b]);
        if (p_en) seq.push_back(p_odd ? (ones % 2 == 0) : (ones % 2 == 1));
        for (int k = 0; k < stops; k++) seq.push_back(1'b1);
        foreach (seq[j]) repeat (d + 1) exp_q.push_back(seq[j]);
    endtask

    task automatic launch(input int s, input logic [7:0] w, input int d, input bit p_en,
                          input bit p_odd, output bit ok);
        int n = 0;
        if (s == 0) div0 = 16'(d); else div1 = 4'(d);
        pen[s] = p_en; podd[s] = p_odd; data[s] = w; valid[s] = 1'b1;
        while (!ready[s] && n < 300) begin
            @(negedge clk);
            n++;
        end
        ok = ready[s];
        if (!ok) begin
            check("ready_wait", {31'b0, ready[s]}, 1);
            valid[s] = 1'b0;
            return;
        end
        @(negedge clk);
        valid[s] = 1'b0;
    endtask

    task automatic run_frame(input int s, input logic [7:0] w, input int d, input bit p_en,
                             input bit p_odd, input bit hold, input logic [7:0] nxt, input int abort_at);
        bit ok;
        int len;
        build(w, d, p_en, p_odd, s == 0 ? 1 : 2);
        len = exp_q.size();
        launch(s, w, d, p_en, p_odd, ok);
        if (!ok) return;
        valid[s] = hold;
        data[s] = nxt;
        if (drop_en) en[s] = 1'b0;
        if (s == 0) div0 = 16'($urandom_range(0, 7)); else div1 = 4'($urandom);
        pen[s] = 1'($urandom);
        podd[s] = 1'($urandom);
        for (int i = 0; i < len; i++) begin
            if (i > 0) @(negedge clk);
            check("frame", {tx[s], busy[s], done[s]}, {exp_q[i], 1'b1, i == len - 1});
            if (i == abort_at) begin
                clr[s] = 1'b1;
                @(negedge clk);
                check("clr_hold", {tx[s], busy[s], done[s]}, {exp_q[i + 1], 2'b10});
                clr[s] = 1'b0;
                @(negedge clk);
                check("clr_idle", {tx[s], busy[s], done[s], ready[s]}, 4'b1001);
                return;
            end
        end
        @(negedge clk);
        check("idle", {tx[s], busy[s], done[s], ready[s]}, {3'b100, en[s]});
    endtask

    initial begin
        bit ok;
        bit have;
        int rs;
        logic [7:0] pend;
        rst_n = 1'b0; clr = '0; en = 2'b11; pen = '0; podd = '0; valid = '0;
        data[0] = '0; data[1] = '0; div0 = '0; div1 = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst0", {tx[0], busy[0], done[0], ready[0]}, 4'b1000);
        check("rst1", {tx[1], busy[1], done[1], ready[1]}, 4'b1000);
        @(negedge clk);
        check("rdy_rise", {ready[1], ready[0]}, 2'b11);

        run_frame(0, 8'hA5, 0, 1'b0, 1'b0, 1'b0, 8'h00, -1);
        run_frame(0, 8'h07, 3, 1'b1, 1'b0, 1'b0, 8'h00, -1);
        run_frame(1, 8'h00, 3, 1'b1, 1'b1, 1'b0, 8'h00, -1);
        run_frame(1, 8'hC3, 15, 1'b1, 1'b0, 1'b0, 8'h00, -1);

        run_frame(0, 8'h11, 1, 1'b0, 1'b0, 1'b1, 8'h22, -1);
        run_frame(0, 8'h22, 1, 1'b1, 1'b0, 1'b1, 8'h33, -1);
        run_frame(0, 8'h33, 0, 1'b0, 1'b0, 1'b0, 8'h00, -1);

        run_frame(0, 8'hB6, 2, 1'b0, 1'b0, 1'b0, 8'h00, 13);
        run_frame(0, 8'h96, 2, 1'b1, 1'b1, 1'b0, 8'h00, -1);

        drop_en = 1'b1;
        run_frame(0, 8'h5C, 1, 1'b0, 1'b0, 1'b1, 8'h6D, -1);
        drop_en = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("en_low_no_accept", {busy[0], ready[0], tx[0]}, 3'b001);
        end
        en[0] = 1'b1;
        run_frame(0, 8'h6D, 0, 1'b0, 1'b0, 1'b0, 8'h00, -1);

        clr[0] = 1'b1;
        @(negedge clk);
        valid[0] = 1'b1;
        data[0] = 8'h3C;
        check("clr_blocks0", {busy[0], ready[0]}, 2'b00);
        @(negedge clk);
        check("clr_blocks1", {busy[0], ready[0]}, 2'b00);
        clr[0] = 1'b0;
        @(negedge clk);
        check("clr_release", {busy[0], ready[0]}, 2'b01);
        run_frame(0, 8'h3C, 1, 1'b1, 1'b0, 1'b0, 8'h00, -1);

        launch(0, 8'h5A, 1, 1'b0, 1'b0, ok);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst0", {tx[0], busy[0], done[0], ready[0]}, 4'b1000);
        check("arst1", {tx[1], busy[1], done[1], ready[1]}, 4'b1000);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("arst_rdy_lo", {tx[0], busy[0], ready[0]}, 3'b100);
        @(negedge clk);
        check("arst_rdy_hi", {tx[0], busy[0], ready[0]}, 3'b101);

        have = 1'b0;
        rs = 0;
        pend = '0;
        for (int i = 0; i < 30; i++) begin
            logic [7:0] w;
            bit hold;
            int d;
            if (!have) rs = int'($urandom_range(0, 1));
            w = have ? pend : 8'($urandom);
            d = (rs == 1 && $urandom_range(0, 3) == 0) ? 15 : int'($urandom_range(0, 3));
            hold = (i < 29) && ($urandom_range(0, 1) == 1);
            pend = 8'($urandom);
            run_frame(rs, w, d, 1'($urandom), 1'($urandom), hold, pend, -1);
            have = hold;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
